// File: rtl/deskew_pkg.sv
// ----------------------------------------------------------------------------
// deskew_pkg
//   Shared defaults for the dual-lane deskew block and a helper that sizes the
//   occupancy counters so they can represent the full value DEPTH.
// ----------------------------------------------------------------------------
package deskew_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // Occupancy counter width: one bit more than the pointer width so that a
  // completely full FIFO (count == DEPTH) is representable.
  function automatic int unsigned cw_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dual_lane_deskew_lane_fifo.sv
// ----------------------------------------------------------------------------
// lane_fifo
//   Single-lane circular FIFO with wrapping read/write pointers and an
//   occupancy counter. A push is accepted when there is room, or when the
//   FIFO is full but is being popped in the same cycle. Otherwise the pushed
//   word is discarded and drop is raised for that cycle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push         a word is offered on push_data
//   push_data    word to store
//   pop          consume the head entry this cycle
//   head         current head entry (valid while count != 0)
//   count        number of stored entries, 0..DEPTH
//   full         count == DEPTH
//   drop         an offered word was discarded this cycle
// ----------------------------------------------------------------------------
module lane_fifo
  import deskew_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned CW   = cw_of(DEPTH),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CW'(DEPTH));
  // A full FIFO that is popped this cycle frees the slot the write lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && (count_q != '0);
  assign drop  = push && !wr_en;
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two DEPTH: the pointer wraps DEPTH-1 -> 0 by natural overflow.
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; entries are
  // never read before being written because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dual_lane_deskew.sv
// ----------------------------------------------------------------------------
// dual_lane_deskew
//   Realigns two skewed lanes (lane 1 trails lane 0) by buffering each lane in
//   its own FIFO and emitting word pairs only when both lanes hold data. The
//   pair is presented on a registered valid/ready output.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in0_valid/in0_data    lane 0 input word
//   in1_valid/in1_data    lane 1 input word
//   out_valid/out_ready   output handshake for the aligned pair
//   out0_data/out1_data   lane 0 / lane 1 words of the pair
//   count0/count1         per-lane FIFO occupancy
//   overflow              sticky per-lane drop flags, bit n = lane n
// ----------------------------------------------------------------------------
module dual_lane_deskew
  import deskew_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CW    = cw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1,
  output logic [1:0]       overflow
);

  logic [WIDTH-1:0] head0, head1;
  logic             full0, full1;
  logic             drop0, drop1;
  logic             pop;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [1:0]       overflow_q, overflow_d;

  // Both lanes pop together, and only when each has a word, so a partial pair
  // is never formed. A held (unaccepted) pair blocks the pop.
  assign pop = (count0 != '0) && (count1 != '0) && (!out_valid_q || out_ready);

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in0_valid),
    .push_data (in0_data),
    .pop       (pop),
    .head      (head0),
    .count     (count0),
    .full      (full0),
    .drop      (drop0)
  );

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in1_valid),
    .push_data (in1_data),
    .pop       (pop),
    .head      (head1),
    .count     (count1),
    .full      (full1),
    .drop      (drop1)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    overflow_d  = overflow_q | {drop1, drop0};
    if (pop) begin
      out_valid_d = 1'b1;
      out0_d      = head0;
      out1_d      = head1;
    end else if (out_valid_q && out_ready) begin
      // Pair consumed with nothing to replace it; data keeps its last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      overflow_q  <= 2'b00;
    end else begin
      out_valid_q <= out_valid_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out0_data = out0_q;
  assign out1_data = out1_q;
  assign overflow  = overflow_q;

  // A lane only discards a word when it is full and not being drained.
  assert property (@(posedge clk) disable iff (!rst_n) drop0 |-> (full0 && !pop));
  assert property (@(posedge clk) disable iff (!rst_n) drop1 |-> (full1 && !pop));

endmodule

// File: tb/tb_dual_lane_deskew.sv
// ----------------------------------------------------------------------------
// tb_dual_lane_deskew
//   Scoreboard bench: accepted input words are queued per lane by a small
//   behavioural model, popped as pairs, and compared with the DUT outputs
//   after every clock edge. Each scenario task adds its own directed checks.
// ----------------------------------------------------------------------------
module tb_dual_lane_deskew;

  localparam int WIDTH = 3;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in1_valid;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CW-1:0]    count0, count1;
  logic [1:0]       overflow;

  int checks = 0;
  int errors = 0;

  // Scoreboard / model state
  logic [WIDTH-1:0] sb_q0 [$];
  logic [WIDTH-1:0] sb_q1 [$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_out0  = '0;
  logic [WIDTH-1:0] m_out1  = '0;
  logic [1:0]       m_ovf   = 2'b00;

  dual_lane_deskew #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .count0    (count0),
    .count1    (count1),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1,
                       input logic rdy);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = rdy;
  endtask

  // Advance one clock edge: predict with the scoreboard from the inputs seen
  // at the edge, then compare every DUT output 1 ns after the edge.
  task automatic step();
    bit pop, w0, w1, d0, d1;
    pop = rst_n && (sb_q0.size() != 0) && (sb_q1.size() != 0) && (!m_valid || out_ready);
    w0  = rst_n && in0_valid && ((sb_q0.size() < DEPTH) || pop);
    w1  = rst_n && in1_valid && ((sb_q1.size() < DEPTH) || pop);
    d0  = rst_n && in0_valid && !w0;
    d1  = rst_n && in1_valid && !w1;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb_q0.delete();
      sb_q1.delete();
      m_valid = 1'b0;
      m_out0  = '0;
      m_out1  = '0;
      m_ovf   = 2'b00;
    end else begin
      if (pop) begin
        m_out0  = sb_q0.pop_front();
        m_out1  = sb_q1.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (w0) sb_q0.push_back(in0_data);
      if (w1) sb_q1.push_back(in1_data);
      m_ovf = m_ovf | {d1, d0};
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL sb_out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
    end
    checks++;
    if (out0_data !== m_out0 || out1_data !== m_out1) begin
      errors++;
      $display("FAIL sb_pair @%0t: got (%0d,%0d) expected (%0d,%0d)",
               $time, out0_data, out1_data, m_out0, m_out1);
    end
    checks++;
    if (count0 !== CW'(sb_q0.size()) || count1 !== CW'(sb_q1.size())) begin
      errors++;
      $display("FAIL sb_counts @%0t: got (%0d,%0d) expected (%0d,%0d)",
               $time, count0, count1, sb_q0.size(), sb_q1.size());
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL sb_overflow @%0t: got %b expected %b", $time, overflow, m_ovf);
    end
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom()),
            1'($urandom_range(0, 1)), 3'($urandom()),
            1'($urandom_range(0, 1)));
      step();
      checks++;
      if ({out_valid, out0_data, out1_data, count0, count1, overflow} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got v=%b d=(%0d,%0d) c=(%0d,%0d) ovf=%b expected all zero",
                 out_valid, out0_data, out1_data, count0, count1, overflow);
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_idle: got out_valid %b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_skew();
    logic [WIDTH-1:0] l1_words [4];
    logic [WIDTH-1:0] exp0 [4];
    int               peak0;
    l1_words = '{3'd5, 3'd6, 3'd7, 3'd0};
    exp0     = '{3'd1, 3'd2, 3'd3, 3'd4};
    peak0    = 0;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      drive(c < 4, 3'(c + 1), (c >= 4) && (c < 8), (c >= 4 && c < 8) ? l1_words[c - 4] : 3'd0, 1'b1);
      step();
      if (int'(count0) > peak0) peak0 = int'(count0);
      if (c >= 5 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out0_data !== exp0[c - 5] || out1_data !== l1_words[c - 5]) begin
          errors++;
          $display("FAIL skew_pair c%0d: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                   c, out_valid, out0_data, out1_data, exp0[c - 5], l1_words[c - 5]);
        end
      end else if (c == 4 || c == 9) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL skew_idle c%0d: got out_valid %b expected 0", c, out_valid);
        end
      end
    end
    checks++;
    if (peak0 != 4) begin
      errors++;
      $display("FAIL skew_peak_count0: got %0d expected 4", peak0);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held0, held1;
    logic [CW-1:0]    c0, c1;
    int               w;
    apply_reset();
    w = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(w), 1'b1, 3'(w + 3), 1'b1);
      w++;
      step();
    end
    held0 = out0_data;
    held1 = out1_data;
    for (int i = 0; i < 5; i++) begin
      c0 = count0;
      c1 = count1;
      drive(1'b1, 3'(w), 1'b1, 3'(w + 3), 1'b0);
      w++;
      step();
      checks++;
      if (out_valid !== 1'b1 || out0_data !== held0 || out1_data !== held1) begin
        errors++;
        $display("FAIL bp_frozen %0d: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                 i, out_valid, out0_data, out1_data, held0, held1);
      end
      checks++;
      if (count0 !== c0 + CW'(1) || count1 !== c1 + CW'(1)) begin
        errors++;
        $display("FAIL bp_growth %0d: got (%0d,%0d) expected (%0d,%0d)",
                 i, count0, count1, c0 + CW'(1), c1 + CW'(1));
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(w), 1'b1, 3'(w + 3), 1'b1);
      w++;
      step();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (count0 !== '0 || count1 !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got c=(%0d,%0d) v=%b expected (0,0) v=0", count0, count1, out_valid);
    end
  endtask

  task automatic test_overflow();
    int pairs;
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 3'(i + 1), 1'b0, '0, 1'b1);
      step();
      if (i == DEPTH - 1) begin
        checks++;
        if (count0 !== CW'(DEPTH) || overflow !== 2'b00) begin
          errors++;
          $display("FAIL ovf_at_full: got c0=%0d ovf=%b expected 16 00", count0, overflow);
        end
      end
      if (i >= DEPTH) begin
        checks++;
        if (count0 !== CW'(DEPTH) || overflow !== 2'b01) begin
          errors++;
          $display("FAIL ovf_dropped w%0d: got c0=%0d ovf=%b expected 16 01", i + 1, count0, overflow);
        end
      end
    end
    pairs = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      drive(1'b0, '0, i < DEPTH, 3'(i), 1'b1);
      step();
      if (out_valid === 1'b1) begin
        checks++;
        if (out0_data !== 3'(pairs + 1)) begin
          errors++;
          $display("FAIL ovf_order pair%0d: got %0d expected %0d", pairs, out0_data, 3'(pairs + 1));
        end
        pairs++;
      end
    end
    checks++;
    if (pairs != DEPTH || count0 !== '0 || overflow !== 2'b01) begin
      errors++;
      $display("FAIL ovf_total: got pairs=%0d c0=%0d ovf=%b expected 16 0 01", pairs, count0, overflow);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0);
      step();
    end
    checks++;
    if (count0 !== CW'(DEPTH) || count1 !== CW'(DEPTH) || out_valid !== 1'b1 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL fullpop_setup: got c=(%0d,%0d) v=%b ovf=%b expected (16,16) 1 00",
               count0, count1, out_valid, overflow);
    end
    drive(1'b1, 3'd5, 1'b0, '0, 1'b1);
    step();
    checks++;
    if (count0 !== CW'(DEPTH) || count1 !== CW'(DEPTH - 1) || overflow !== 2'b00 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_accept: got c=(%0d,%0d) v=%b ovf=%b expected (16,15) 1 00",
               count0, count1, out_valid, overflow);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step();
    checks++;
    if (count0 !== CW'(1) || count1 !== '0) begin
      errors++;
      $display("FAIL fullpop_residue: got c=(%0d,%0d) expected (1,0)", count0, count1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i + 2), i == 0, 3'd4, 1'b0);
      step();
    end
    checks++;
    if (count0 !== CW'(7) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got c0=%0d v=%b expected 7 1", count0, out_valid);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count0 !== '0 || count1 !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got c=(%0d,%0d) v=%b expected (0,0) 0", count0, count1, out_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 3'd6, 1'b1, 3'd3, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out0_data !== 3'd6 || out1_data !== 3'd3) begin
      errors++;
      $display("FAIL midrst_first_pair: got v=%b (%0d,%0d) expected v=1 (6,3)",
               out_valid, out0_data, out1_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    test_reset();
    test_skew();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
